// File: rtl/rng_bit_pool_pkg.sv
// Shared definitions for the random-bit pool: FSM states and read-length codes.
// Length codes map to a quarter, half or full read word.
package rng_bit_pool_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] LEN_QTR  = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_FULL = 2'd2;

    function automatic int len_decode(input logic [1:0] code, input int word_w);
        case (code)
            LEN_QTR:  return word_w / 4;
            LEN_HALF: return word_w / 2;
            LEN_FULL: return word_w;
            default:  return word_w;
        endcase
    endfunction

endpackage

// File: rtl/rng_rep_monitor.sv
// Repetition-count health test: trips when REP_LIMIT identical bits arrive in a row.
// o_trip flags the tripping bit combinationally so the caller can keep it out of the pool.
module rng_rep_monitor #(
    parameter int REP_LIMIT = 34
) (
    input  logic i_clock,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_bit,
    input  logic i_valid,
    output logic o_fail,
    output logic o_trip
);

    localparam int RUN_W = $clog2(REP_LIMIT + 1);

    logic             last;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_next;
    logic             fail;

    always_comb begin
        run_next = RUN_W'(1);
        if (run != '0 && i_bit == last) begin
            run_next = run + RUN_W'(1);
        end
    end

    assign o_trip = i_valid & ~fail & (run_next == RUN_W'(REP_LIMIT));
    assign o_fail = fail;

    always_ff @(posedge i_clock or posedge i_rst) begin
        if (i_rst) begin
            last <= 1'b0;
            run  <= '0;
            fail <= 1'b0;
        end else if (i_clr) begin
            last <= 1'b0;
            run  <= '0;
            fail <= 1'b0;
        end else if (i_valid && !fail) begin
            last <= i_bit;
            run  <= run_next;
            if (o_trip) begin
                fail <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/rng_bit_pool.sv
// Compacting pool of serial random bits with quarter/half/full-word reads.
// Oldest bit sits at pool[0]; reads shift the pool down and may absorb a new bit in the same cycle.
module rng_bit_pool
    import rng_bit_pool_pkg::*;
#(
    parameter int DEPTH     = 256,
    parameter int WORD_W    = 32,
    parameter int REP_LIMIT = 34,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              i_clock,
    input  logic              i_rst,
    input  logic              i_enb,
    input  logic              i_ranBit,
    input  logic              i_ranBitValid,
    input  logic              i_rdReq,
    input  logic [1:0]        i_rdLen,
    output logic [WORD_W-1:0] o_rdData,
    output logic              o_rdValid,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_overflow,
    output logic              o_healthFail
);

    localparam logic [WORD_W-1:0] ONES = '1;

    state_t            state;
    state_t            state_n;
    logic [DEPTH-1:0]  pool;
    logic [DEPTH-1:0]  pool_n;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_n;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  len_cur;
    logic [WORD_W-1:0] data;
    logic [WORD_W-1:0] data_n;
    logic              ovf;
    logic              ovf_n;
    logic              fail;
    logic              trip;
    logic              bit_in;
    logic              consume;

    rng_rep_monitor #(
        .REP_LIMIT (REP_LIMIT)
    ) u_rep (
        .i_clock (i_clock),
        .i_rst   (i_rst),
        .i_clr   (~i_enb),
        .i_bit   (i_ranBit),
        .i_valid (i_ranBitValid & i_enb),
        .o_fail  (fail),
        .o_trip  (trip)
    );

    assign bit_in = i_ranBitValid & ~fail & ~trip;

    // A fresh request uses the live length code; a waiting one keeps the latched length.
    always_comb begin
        len_cur = (state == S_IDLE) ? CNT_W'(len_decode(i_rdLen, WORD_W)) : len_q;
        consume = i_rdReq & (state != S_RESP) & ~fail & ~trip & (count >= len_cur);
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (i_rdReq) begin
                    state_n = consume ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!i_rdReq) begin
                    state_n = S_IDLE;
                end else if (consume) begin
                    state_n = S_RESP;
                end
            end
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Consume first, then append, so a read always frees room for the incoming bit.
    always_comb begin
        pool_n  = pool;
        count_n = count;
        data_n  = data;
        ovf_n   = ovf;
        if (trip) begin
            pool_n  = '0;
            count_n = '0;
        end else begin
            if (consume) begin
                pool_n  = pool >> len_cur;
                count_n = count - len_cur;
                data_n  = pool[WORD_W-1:0] & (ONES >> (CNT_W'(WORD_W) - len_cur));
            end
            if (bit_in) begin
                if (count_n < CNT_W'(DEPTH)) begin
                    pool_n  = pool_n | (DEPTH'(i_ranBit) << count_n);
                    count_n = count_n + CNT_W'(1);
                end else begin
                    ovf_n = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
            pool  <= '0;
            count <= '0;
            len_q <= '0;
            data  <= '0;
            ovf   <= 1'b0;
        end else if (!i_enb) begin
            state <= S_IDLE;
            pool  <= '0;
            count <= '0;
            len_q <= '0;
            data  <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            pool  <= pool_n;
            count <= count_n;
            data  <= data_n;
            ovf   <= ovf_n;
            if (state == S_IDLE && i_rdReq) begin
                len_q <= len_cur;
            end
        end
    end

    assign o_rdData     = data;
    assign o_rdValid    = (state == S_RESP);
    assign o_count      = count;
    assign o_full       = (count == CNT_W'(DEPTH));
    assign o_overflow   = ovf;
    assign o_healthFail = fail;

endmodule

// File: tb/tb_rng_bit_pool.sv
// Randomised bench for rng_bit_pool against a queue-based reference model.
module tb_rng_bit_pool;

    localparam int DEPTH     = 256;
    localparam int WORD_W    = 32;
    localparam int REP_LIMIT = 34;
    localparam int CNT_W     = 9;
    localparam int PH_IDLE   = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_RESP   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              enb;
    logic              rbit;
    logic              rvalid;
    logic              req;
    logic [1:0]        len;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              ovf;
    logic              hfail;

    int n_chk  = 0;
    int n_pass = 0;

    bit          mq[$];
    int          m_phase;
    int          m_len;
    logic [31:0] m_data;
    bit          m_ovf;
    bit          m_hf;
    bit          m_last;
    int          m_run;

    always #5 clk = ~clk;

    rng_bit_pool #(
        .DEPTH     (DEPTH),
        .WORD_W    (WORD_W),
        .REP_LIMIT (REP_LIMIT)
    ) dut (
        .i_clock       (clk),
        .i_rst         (rst),
        .i_enb         (enb),
        .i_ranBit      (rbit),
        .i_ranBitValid (rvalid),
        .i_rdReq       (req),
        .i_rdLen       (len),
        .o_rdData      (rd_data),
        .o_rdValid     (rd_valid),
        .o_count       (count),
        .o_full        (full),
        .o_overflow    (ovf),
        .o_healthFail  (hfail)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int dec(input logic [1:0] c);
        case (c)
            2'd0:    return WORD_W / 4;
            2'd1:    return WORD_W / 2;
            default: return WORD_W;
        endcase
    endfunction

    task automatic model_clear();
        mq.delete();
        m_phase = PH_IDLE;
        m_len   = 0;
        m_data  = '0;
        m_ovf   = 0;
        m_hf    = 0;
        m_last  = 0;
        m_run   = 0;
    endtask

    task automatic model_step();
        bit trip;
        bit offered;
        if (!enb) begin
            model_clear();
            return;
        end
        offered = rvalid && !m_hf;
        trip    = 0;
        if (offered) begin
            if (m_run > 0 && rbit == m_last) m_run++;
            else m_run = 1;
            m_last = rbit;
            trip   = (m_run == REP_LIMIT);
        end
        if (m_phase == PH_RESP) m_phase = PH_IDLE;
        else if (!req) m_phase = PH_IDLE;
        else begin
            if (m_phase == PH_IDLE) m_len = dec(len);
            if (!m_hf && !trip && mq.size() >= m_len) begin
                m_data = '0;
                for (int i = 0; i < m_len; i++) m_data[i] = mq.pop_front();
                m_phase = PH_RESP;
            end else begin
                m_phase = PH_WAIT;
            end
        end
        if (trip) begin
            mq.delete();
            m_hf = 1;
        end else if (offered) begin
            if (mq.size() < DEPTH) mq.push_back(rbit);
            else m_ovf = 1;
        end
    endtask

    always @(posedge clk) if (!rst) model_step();

    task automatic check_all();
        check("count", 32'(count), 32'(mq.size()));
        check("valid", 32'(rd_valid), 32'(m_phase == PH_RESP));
        check("data", rd_data, m_data);
        check("overflow", 32'(ovf), 32'(m_ovf));
        check("full", 32'(full), 32'(mq.size() == DEPTH));
        check("health", 32'(hfail), 32'(m_hf));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input bit v, input bit b, input bit r, input logic [1:0] l);
        rvalid = v;
        rbit   = b;
        req    = r;
        len    = l;
        tick();
    endtask

    task automatic flush();
        enb = 1'b0;
        drive(0, 0, 0, 0);
        enb = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit          b0;
        bit          bits[16];
        logic [31:0] e16;
        bit          got;
        int          pulses;
        int          cyc;
        int          last_cyc;

        rst = 1'b1; enb = 1'b1; rbit = 0; rvalid = 0; req = 0; len = 0;
        model_clear();
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // alternating bits then a full-word read
        flush();
        b0 = 1'($urandom % 2);
        for (int i = 0; i < 40; i++) drive(1, b0 ^ 1'(i & 1), 0, 0);
        drive(0, 0, 1, 2);
        check("t2_lat", 32'(rd_valid), 32'd1);
        check("t2_data", rd_data, b0 ? 32'h55555555 : 32'hAAAAAAAA);
        check("t2_cnt", 32'(count), 32'd8);
        drive(0, 0, 0, 0);

        // half-word read waits for bits
        flush();
        for (int i = 0; i < 10; i++) begin
            bits[i] = 1'($urandom % 2);
            drive(1, bits[i], 0, 0);
        end
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 1);
        check("t3_wait", 32'(rd_valid), 32'd0);
        for (int i = 10; i < 16; i++) begin
            bits[i] = 1'($urandom % 2);
            drive(1, bits[i], 1, 1);
        end
        got = 0;
        for (int k = 0; k < 8 && !got; k++) begin
            drive(0, 0, 1, 1);
            if (rd_valid) got = 1;
        end
        check("t3_timeout", 32'(got), 32'd1);
        e16 = '0;
        for (int i = 0; i < 16; i++) e16[i] = bits[i];
        check("t3_data", rd_data, e16);
        check("t3_cnt", 32'(count), 32'd0);
        drive(0, 0, 0, 0);

        // full pool, overflow, then read with concurrent write
        flush();
        for (int i = 0; i < DEPTH; i++) drive(1, 1'($urandom % 2), 0, 0);
        check("t4_full", 32'(full), 32'd1);
        drive(1, 1, 0, 0);
        check("t4_ovf", 32'(ovf), 32'd1);
        drive(1, 1, 1, 0);
        check("t4_cnt", 32'(count), 32'd249);
        check("t4_ovf_sticky", 32'(ovf), 32'd1);
        check("t4_valid", 32'(rd_valid), 32'd1);

        // asynchronous reset while a response is showing
        req = 0; rvalid = 0;
        #2 rst = 1'b1;
        #1;
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_cnt", 32'(count), 32'd0);
        check("rst_data", rd_data, 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        model_clear();
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // repetition health failure
        flush();
        for (int i = 0; i < REP_LIMIT - 1; i++) drive(1, 1, 0, 0);
        check("t5_pre_cnt", 32'(count), 32'(REP_LIMIT - 1));
        check("t5_pre_hf", 32'(hfail), 32'd0);
        drive(1, 1, 0, 0);
        check("t5_hf", 32'(hfail), 32'd1);
        check("t5_cnt", 32'(count), 32'd0);
        for (int i = 0; i < 5; i++) drive(1, 1'($urandom % 2), 1, 0);
        check("t5_ignored", 32'(count), 32'd0);
        drive(0, 0, 0, 0);
        flush();
        check("t5_clr", 32'(hfail), 32'd0);

        // back-to-back reads with request held
        flush();
        for (int i = 0; i < 96; i++) drive(1, 1'($urandom % 2), 0, 0);
        pulses = 0; cyc = 0; last_cyc = 0;
        for (int k = 0; k < 20 && pulses < 3; k++) begin
            drive(0, 0, 1, 2);
            cyc++;
            if (rd_valid) begin
                if (pulses > 0) check("t6_gap", 32'(cyc - last_cyc), 32'd2);
                last_cyc = cyc;
                pulses++;
            end
        end
        check("t6_pulses", 32'(pulses), 32'd3);
        check("t6_cnt", 32'(count), 32'd0);
        drive(0, 0, 1, 2);
        drive(0, 0, 1, 2);
        drive(0, 0, 0, 2);
        check("t6_abandon", 32'(rd_valid), 32'd0);
        drive(0, 0, 0, 2);
        check("t6_idle", 32'(rd_valid), 32'd0);

        // random traffic
        flush();
        for (int i = 0; i < 800; i++) begin
            enb = ($urandom % 150) != 0;
            drive(($urandom % 4) != 0, 1'($urandom % 2), ($urandom % 8) != 0, 2'($urandom % 4));
        end
        enb = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
